// File: rtl/instruction_fetch_unit_if.sv
// Decode-side handshake between the fetch stage (master) and the decode stage (slave).
interface instruction_fetch_unit_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
);
   logic                     instr_valid;
   logic [DATA_WIDTH-1:0]    instr_data;
   logic [ADDRESS_WIDTH-1:0] instr_pc;
   logic                     instr_ready;

   modport master (
      output instr_valid,
      output instr_data,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_data,
      input  instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC fetch stage feeding a synchronous ROM: issues addresses under a credit limit,
// captures returned words into a 2-entry buffer and hands them to decode.
module instruction_fetch_unit #(
   parameter int                       ADDRESS_WIDTH = 8,
   parameter int                       DATA_WIDTH    = 8,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   output logic                     rom_read_enable,
   output logic [ADDRESS_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0]    rom_data,
   input  logic                     branch_valid,
   input  logic [ADDRESS_WIDTH-1:0] branch_target,
   instruction_fetch_unit_if.master instr_bus
);
   localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDRESS_WIDTH-1:0] pc_reg;
   logic [ADDRESS_WIDTH-1:0] inflight_pc_reg;
   logic                     inflight_reg;
   logic [1:0]               count_reg;
   logic [1:0]               count_next;
   logic [DATA_WIDTH-1:0]    fifo_data_reg [2];
   logic [DATA_WIDTH-1:0]    fifo_data_next [2];
   logic [ADDRESS_WIDTH-1:0] fifo_pc_reg [2];
   logic [ADDRESS_WIDTH-1:0] fifo_pc_next [2];

   logic       pop;
   logic       push;
   logic       issue;
   logic       wr_slot;
   logic [2:0] credit_used;

   assign pop  = instr_bus.instr_valid & instr_bus.instr_ready;
   assign push = inflight_reg & ~branch_valid;

   // Words already buffered or on their way back, less the one leaving this cycle.
   assign credit_used = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign issue       = reset_n & enable & ~branch_valid & (credit_used < 3'd2);

   assign rom_read_enable = issue;
   assign rom_address     = pc_reg;

   assign instr_bus.instr_valid = (count_reg != 2'd0);
   assign instr_bus.instr_data  = fifo_data_reg[0];
   assign instr_bus.instr_pc    = fifo_pc_reg[0];

   // Slot 0 is always the head; a word lands behind whatever survives this cycle's pop.
   assign wr_slot = (count_reg == 2'd2) | ((count_reg == 2'd1) & ~pop);

   always_comb begin
      fifo_data_next = fifo_data_reg;
      fifo_pc_next   = fifo_pc_reg;
      count_next     = count_reg + {1'b0, push} - {1'b0, pop};
      // The head is left untouched on a flush so the outputs keep their last value.
      if (pop && (count_reg == 2'd2) && !branch_valid) begin
         fifo_data_next[0] = fifo_data_reg[1];
         fifo_pc_next[0]   = fifo_pc_reg[1];
      end
      if (push) begin
         fifo_data_next[wr_slot] = rom_data;
         fifo_pc_next[wr_slot]   = inflight_pc_reg;
      end
      if (branch_valid) begin
         count_next = 2'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc_reg          <= RESET_VECTOR;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
         count_reg       <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_reg[i] <= '0;
            fifo_pc_reg[i]   <= '0;
         end
      end else begin
         inflight_reg <= issue;
         count_reg    <= count_next;
         if (branch_valid) begin
            pc_reg <= branch_target;
         end else if (issue) begin
            pc_reg          <= pc_reg + PC_ONE;
            inflight_pc_reg <= pc_reg;
         end
         for (int i = 0; i < 2; i++) begin
            fifo_data_reg[i] <= fifo_data_next[i];
            fifo_pc_reg[i]   <= fifo_pc_next[i];
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_instruction_fetch_unit;
   localparam int             AW = 8;
   localparam int             DW = 8;
   localparam logic [AW-1:0]  RV = 8'h10;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] data;
   } word_t;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          rom_read_enable;
   logic [AW-1:0] rom_address;
   logic [DW-1:0] rom_data = '0;
   logic          branch_valid;
   logic [AW-1:0] branch_target;

   logic [DW-1:0] rom_mem [256];

   int check_count = 0;
   int pass_count  = 0;

   // Reference model state
   logic [AW-1:0] m_pc;
   bit            m_inflight;
   logic [AW-1:0] m_inflight_pc;
   word_t         m_fifo[$];
   word_t         m_shown;
   bit            m_known = 0;
   bit            m_pop;
   bit            m_issue;
   bit            s_rst;
   bit            s_br;
   logic [AW-1:0] s_tgt;
   logic [AW-1:0] held_pc;

   always #5 clock = ~clock;

   instruction_fetch_unit_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) instr_bus_i ();

   instruction_fetch_unit #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .RESET_VECTOR (RV)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .enable         (enable),
      .rom_read_enable(rom_read_enable),
      .rom_address    (rom_address),
      .rom_data       (rom_data),
      .branch_valid   (branch_valid),
      .branch_target  (branch_target),
      .instr_bus      (instr_bus_i)
   );

   // Synchronous ROM: word for the address issued in one cycle is visible the next.
   always @(posedge clock) begin
      if (rom_read_enable) rom_data <= rom_mem[rom_address];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end else begin
         pass_count++;
      end
   endtask

   // Apply inputs for this cycle and compare the DUT against the model's view of it.
   task automatic drive(input bit rst_i, input bit en_i, input bit br_i,
                        input logic [AW-1:0] tgt_i, input bit rdy_i);
      word_t head;
      reset_n                 = rst_i;
      enable                  = en_i;
      branch_valid            = br_i;
      branch_target           = tgt_i;
      instr_bus_i.instr_ready = rdy_i;
      s_rst = rst_i;
      s_br  = br_i;
      s_tgt = tgt_i;
      #1;
      m_pop   = (m_fifo.size() != 0) && rdy_i;
      m_issue = rst_i && en_i && !br_i &&
                ((int'(m_fifo.size()) + int'(m_inflight) - int'(m_pop)) < 2);
      check("rom_read_enable", rom_read_enable, m_issue);
      if (m_known) begin
         head = (m_fifo.size() != 0) ? m_fifo[0] : m_shown;
         check("rom_address", rom_address, m_pc);
         check("instr_valid", instr_bus_i.instr_valid, m_fifo.size() != 0);
         check("instr_pc", instr_bus_i.instr_pc, head.pc);
         check("instr_data", instr_bus_i.instr_data, head.data);
      end
   endtask

   task automatic tick();
      word_t w;
      @(posedge clock);
      if (!s_rst) begin
         m_pc       = RV;
         m_inflight = 0;
         m_fifo.delete();
         m_shown    = '0;
         m_known    = 1;
      end else begin
         if (m_pop) void'(m_fifo.pop_front());
         if (s_br) begin
            m_fifo.delete();
            m_inflight = 0;
            m_pc       = s_tgt;
         end else begin
            if (m_inflight) begin
               w.pc   = m_inflight_pc;
               w.data = rom_mem[m_inflight_pc];
               m_fifo.push_back(w);
            end
            if (m_issue) begin
               m_inflight_pc = m_pc;
               m_pc          = m_pc + 8'd1;
            end
            m_inflight = m_issue;
         end
         if (m_fifo.size() != 0) m_shown = m_fifo[0];
      end
      @(negedge clock);
   endtask

   task automatic cyc(input bit rst_i, input bit en_i, input bit br_i,
                      input logic [AW-1:0] tgt_i, input bit rdy_i);
      drive(rst_i, en_i, br_i, tgt_i, rdy_i);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);

      // Reset, then free-running start from the reset vector
      cyc(0, 1, 1, 8'h55, 1);
      cyc(0, 1, 0, 8'h00, 1);
      for (int c = 0; c < 4; c++) begin
         drive(1, 1, 0, 8'h00, 1);
         if (c <= 2) check("start_addr", rom_address, RV + c);
         if (c >= 2) begin
            check("start_pc", instr_bus_i.instr_pc, RV + c - 2);
            check("start_data", instr_bus_i.instr_data, rom_mem[RV + c - 2]);
         end
         tick();
      end

      // Branch while 0x13 is in flight, popping 0x12 in the same cycle
      drive(1, 1, 1, 8'h40, 1);
      check("br_pop_pc", instr_bus_i.instr_pc, 8'h12);
      tick();
      drive(1, 1, 0, 8'h00, 1);
      check("br_empty_t1", instr_bus_i.instr_valid, 0);
      check("br_issue_addr", rom_address, 8'h40);
      tick();
      drive(1, 1, 0, 8'h00, 1);
      check("br_empty_t2", instr_bus_i.instr_valid, 0);
      tick();
      drive(1, 1, 0, 8'h00, 1);
      check("br_target_pc", instr_bus_i.instr_pc, 8'h40);
      check("br_target_valid", instr_bus_i.instr_valid, 1);
      tick();
      for (int c = 0; c < 3; c++) cyc(1, 1, 0, 8'h00, 1);

      // Backpressure: outputs frozen, no issue while the buffer is full
      held_pc = instr_bus_i.instr_pc;
      for (int c = 0; c < 5; c++) begin
         drive(1, 1, 0, 8'h00, 0);
         check("bp_no_issue", rom_read_enable, 0);
         check("bp_valid", instr_bus_i.instr_valid, 1);
         check("bp_held_pc", instr_bus_i.instr_pc, held_pc);
         tick();
      end
      drive(1, 1, 0, 8'h00, 1);
      check("bp_resume_pc", instr_bus_i.instr_pc, held_pc);
      tick();
      for (int c = 0; c < 5; c++) cyc(1, 1, 0, 8'h00, 1);

      // PC wrap past the top of the address space
      cyc(1, 1, 1, 8'hFE, 1);
      for (int k = 1; k <= 6; k++) begin
         drive(1, 1, 0, 8'h00, 1);
         if (k >= 3) check("wrap_pc", instr_bus_i.instr_pc, (32'hFE + k - 3) & 32'hFF);
         tick();
      end

      // Reset with a full buffer
      for (int c = 0; c < 3; c++) cyc(1, 1, 0, 8'h00, 0);
      drive(0, 1, 0, 8'h00, 0);
      check("rst_no_issue", rom_read_enable, 0);
      tick();
      drive(1, 1, 0, 8'h00, 1);
      check("rst_valid", instr_bus_i.instr_valid, 0);
      check("rst_restart_addr", rom_address, RV);
      check("rst_restart_issue", rom_read_enable, 1);
      tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         cyc($urandom_range(0, 199) != 0,
             $urandom_range(0, 99) < 85,
             $urandom_range(0, 99) < 10,
             AW'($urandom),
             $urandom_range(0, 99) < 70);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
